// File: rtl/mc_pkg.sv
// Shared constants and control bundle for the multicycle control FSM.
// MC_ITYPE_EN adds the EXECI state and the I-type ALU opcode.
package mc_pkg;

  localparam logic [3:0] ST_FETCH    = 4'd0;
  localparam logic [3:0] ST_DECODE   = 4'd1;
  localparam logic [3:0] ST_MEMADR   = 4'd2;
  localparam logic [3:0] ST_MEMREAD  = 4'd3;
  localparam logic [3:0] ST_MEMWB    = 4'd4;
  localparam logic [3:0] ST_MEMWRITE = 4'd5;
  localparam logic [3:0] ST_EXECR    = 4'd6;
  localparam logic [3:0] ST_ALUWB    = 4'd7;
  localparam logic [3:0] ST_BEQ      = 4'd8;
`ifdef MC_ITYPE_EN
  localparam logic [3:0] ST_EXECI    = 4'd9;
  localparam logic [6:0] OPC_ITYPE   = 7'b0010011;
`endif

  localparam logic [6:0] OPC_LW    = 7'b0000011;
  localparam logic [6:0] OPC_SW    = 7'b0100011;
  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_BEQ   = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       adr_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] alu_op;
    logic [3:0] alu_func;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decoder.sv
// Moore output decode: state (plus funct, zero, mem_ready) to strobes.
// MC_ITYPE_EN adds EXECI decode.
module mc_ctrl_decoder
  import mc_pkg::*;
(
  input  logic       active,
  input  logic [3:0] state,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    if (active) begin
      unique case (1'b1)
        (state == ST_FETCH): begin
          ctrl.mem_read   = 1'b1;
          ctrl.alu_src_a  = SRCA_PC;
          ctrl.alu_src_b  = SRCB_FOUR;
          ctrl.alu_op     = ALUOP_ADD;
          ctrl.result_src = RES_ALU;
          ctrl.ir_write   = mem_ready;
          ctrl.pc_write   = mem_ready;
        end
        (state == ST_DECODE): begin
          ctrl.alu_src_a = SRCA_OLDPC;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = ALUOP_ADD;
        end
        (state == ST_MEMADR): begin
          ctrl.alu_src_a = SRCA_RS1;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = ALUOP_ADD;
        end
        (state == ST_MEMREAD): begin
          ctrl.mem_read   = 1'b1;
          ctrl.adr_src    = 1'b1;
          ctrl.result_src = RES_ALUOUT;
        end
        (state == ST_MEMWB): begin
          ctrl.result_src = RES_RDATA;
          ctrl.reg_write  = 1'b1;
        end
        (state == ST_MEMWRITE): begin
          ctrl.mem_write = 1'b1;
          ctrl.adr_src   = 1'b1;
        end
        (state == ST_EXECR): begin
          ctrl.alu_src_a = SRCA_RS1;
          ctrl.alu_src_b = SRCB_RS2;
          ctrl.alu_op    = ALUOP_FUNCT;
          ctrl.alu_func  = {funct7_5, funct3};
        end
`ifdef MC_ITYPE_EN
        // funct7_5 is immediate bits for I-type, so it is masked
        (state == ST_EXECI): begin
          ctrl.alu_src_a = SRCA_RS1;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = ALUOP_FUNCT;
          ctrl.alu_func  = {1'b0, funct3};
        end
`endif
        (state == ST_ALUWB): begin
          ctrl.result_src = RES_ALUOUT;
          ctrl.reg_write  = 1'b1;
        end
        (state == ST_BEQ): begin
          ctrl.alu_src_a  = SRCA_RS1;
          ctrl.alu_src_b  = SRCB_RS2;
          ctrl.alu_op     = ALUOP_SUB;
          ctrl.result_src = RES_ALUOUT;
          ctrl.pc_write   = zero;
        end
        default: ctrl = '0;
      endcase
    end
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle RISC-V control FSM: state register and next-state logic.
// MC_ITYPE_EN enables the I-type ALU path through EXECI.
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter int IR_WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       illegal,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] alu_op,
  output logic [3:0] alu_func,
  output logic [3:0] state_o
);

  // an IR too narrow to carry instr[30] cannot feed a legal decode
  localparam logic IR_OK = (IR_WIDTH >= 31);

  logic [3:0] state;
  logic [3:0] state_nxt;
  logic       bad_op;
  logic       illegal_q;
  ctrl_t      ctrl;

  always_comb begin
    state_nxt = state;
    bad_op    = 1'b0;
    unique case (1'b1)
      (state == ST_FETCH):
        if (mem_ready) state_nxt = ST_DECODE;
      (state == ST_DECODE): begin
        state_nxt = ST_FETCH;
        unique case (1'b1)
          (IR_OK && opcode == OPC_LW):    state_nxt = ST_MEMADR;
          (IR_OK && opcode == OPC_SW):    state_nxt = ST_MEMADR;
          (IR_OK && opcode == OPC_RTYPE): state_nxt = ST_EXECR;
          (IR_OK && opcode == OPC_BEQ):   state_nxt = ST_BEQ;
`ifdef MC_ITYPE_EN
          (IR_OK && opcode == OPC_ITYPE): state_nxt = ST_EXECI;
`endif
          default:                        bad_op = 1'b1;
        endcase
      end
      (state == ST_MEMADR):
        state_nxt = (opcode == OPC_LW) ? ST_MEMREAD : ST_MEMWRITE;
      (state == ST_MEMREAD):
        if (mem_ready) state_nxt = ST_MEMWB;
      (state == ST_MEMWRITE):
        if (mem_ready) state_nxt = ST_FETCH;
      (state == ST_EXECR):    state_nxt = ST_ALUWB;
`ifdef MC_ITYPE_EN
      (state == ST_EXECI):    state_nxt = ST_ALUWB;
`endif
      (state == ST_MEMWB):    state_nxt = ST_FETCH;
      (state == ST_ALUWB):    state_nxt = ST_FETCH;
      (state == ST_BEQ):      state_nxt = ST_FETCH;
      default:                state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (bad_op) illegal_q <= 1'b1;
    end
  end

  mc_ctrl_decoder u_dec (
    .active    (!rst),
    .state     (state),
    .funct3    (funct3),
    .funct7_5  (funct7_5),
    .zero      (zero),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign pc_write   = ctrl.pc_write;
  assign ir_write   = ctrl.ir_write;
  assign adr_src    = ctrl.adr_src;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign reg_write  = ctrl.reg_write;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign result_src = ctrl.result_src;
  assign alu_op     = ctrl.alu_op;
  assign alu_func   = ctrl.alu_func;
  assign illegal    = illegal_q & ~rst;
  assign state_o    = state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm; checks state, strobes and illegal.
// Build with +define+MC_ITYPE_EN to exercise EXECI.
module tb_mc_control_fsm;
  import mc_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, ir_write, adr_src, mem_read;
  logic       mem_write, reg_write, illegal;
  logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
  logic [3:0] alu_func, state_o;

  int checks = 0;
  int passes = 0;

  mc_control_fsm #(.IR_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7_5   (funct7_5),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .adr_src    (adr_src),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .illegal    (illegal),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .result_src (result_src),
    .alu_op     (alu_op),
    .alu_func   (alu_func),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] cw(
    input logic pcw, irw, adr, mr, mw, rw,
    input logic [1:0] sa, sb, rs, op,
    input logic [3:0] fn
  );
    return {pcw, irw, adr, mr, mw, rw, sa, sb, rs, op, fn};
  endfunction

  function automatic logic [17:0] w_fetch(input logic m);
    return cw(m, m, 0, 1, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 4'h0);
  endfunction

  logic [17:0] W_ZERO, W_DEC, W_MADR, W_MRD, W_MWB;
  logic [17:0] W_MWR, W_AWB;

  function automatic logic [17:0] dut_word();
    return {pc_write, ir_write, adr_src, mem_read, mem_write,
            reg_write, alu_src_a, alu_src_b, result_src,
            alu_op, alu_func};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step(input string tag, input logic [3:0] st,
                      input logic [17:0] w, input logic ill);
    chk({tag, ".state"}, 32'(state_o), 32'(st));
    chk({tag, ".ctrl"}, 32'(dut_word()), 32'(w));
    chk({tag, ".illegal"}, 32'(illegal), 32'(ill));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    W_ZERO = '0;
    W_DEC  = cw(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 4'h0);
    W_MADR = cw(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 4'h0);
    W_MRD  = cw(0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0);
    W_MWB  = cw(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01, 2'b00, 4'h0);
    W_MWR  = cw(0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0);
    W_AWB  = cw(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0);

    rst = 1'b1; opcode = '0; funct3 = '0; funct7_5 = 1'b0;
    zero = 1'b0; mem_ready = 1'b0;
    tick();
    step("rst", ST_FETCH, W_ZERO, 1'b0);
    mem_ready = 1'b1;
    settle();
    chk("rst_memready.ctrl", 32'(dut_word()), 32'(W_ZERO));
    tick();
    chk("rst_hold.state", 32'(state_o), 32'(ST_FETCH));

    rst = 1'b0; mem_ready = 1'b0;
    settle();
    step("fetch_wait", ST_FETCH, w_fetch(1'b0), 1'b0);
    tick();
    step("fetch_hold", ST_FETCH, w_fetch(1'b0), 1'b0);

    // R-type sub: 4 cycles, back in FETCH on cycle 5
    opcode = 7'b0110011; funct7_5 = 1'b1; funct3 = 3'b000;
    mem_ready = 1'b1;
    settle();
    step("r.c1", ST_FETCH, w_fetch(1'b1), 1'b0);
    tick();
    step("r.c2", ST_DECODE, W_DEC, 1'b0);
    tick();
    step("r.c3", ST_EXECR,
         cw(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b10, 4'b1000),
         1'b0);
    tick();
    step("r.c4", ST_ALUWB, W_AWB, 1'b0);
    tick();
    step("r.c5", ST_FETCH, w_fetch(1'b1), 1'b0);

    // lw with memory stalling three cycles
    opcode = 7'b0000011; funct7_5 = 1'b0; funct3 = 3'b010;
    tick();
    step("lw.dec", ST_DECODE, W_DEC, 1'b0);
    tick();
    step("lw.adr", ST_MEMADR, W_MADR, 1'b0);
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      step("lw.stall", ST_MEMREAD, W_MRD, 1'b0);
      if (i < 2) tick();
    end
    mem_ready = 1'b1;
    settle();
    step("lw.rdy", ST_MEMREAD, W_MRD, 1'b0);
    tick();
    step("lw.wb", ST_MEMWB, W_MWB, 1'b0);
    tick();
    step("lw.done", ST_FETCH, w_fetch(1'b1), 1'b0);

    // sw: 4 cycles
    opcode = 7'b0100011;
    tick();
    tick();
    step("sw.adr", ST_MEMADR, W_MADR, 1'b0);
    tick();
    step("sw.wr", ST_MEMWRITE, W_MWR, 1'b0);
    tick();
    step("sw.done", ST_FETCH, w_fetch(1'b1), 1'b0);

    // beq taken, then not taken
    opcode = 7'b1100011; zero = 1'b1;
    tick();
    tick();
    step("beq1", ST_BEQ,
         cw(1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b01, 4'h0), 1'b0);
    tick();
    step("beq1.done", ST_FETCH, w_fetch(1'b1), 1'b0);
    zero = 1'b0;
    tick();
    tick();
    step("beq0", ST_BEQ,
         cw(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b01, 4'h0), 1'b0);
    tick();
    step("beq0.done", ST_FETCH, w_fetch(1'b1), 1'b0);

    // illegal opcode: flag appears the cycle after DECODE, sticky
    opcode = 7'b1111111;
    tick();
    step("ill.dec", ST_DECODE, W_DEC, 1'b0);
    tick();
    step("ill.fetch", ST_FETCH, w_fetch(1'b1), 1'b1);

    // sw stalled in MEMWRITE, then reset
    opcode = 7'b0100011;
    tick();
    tick();
    mem_ready = 1'b0;
    tick();
    step("swr.wait", ST_MEMWRITE, W_MWR, 1'b1);
    tick();
    step("swr.hold", ST_MEMWRITE, W_MWR, 1'b1);
    rst = 1'b1;
    settle();
    chk("swr.rst.ctrl", 32'(dut_word()), 32'(W_ZERO));
    tick();
    rst = 1'b0;
    settle();
    step("swr.after", ST_FETCH, w_fetch(1'b0), 1'b0);

    // I-type opcode
    opcode = 7'b0010011; funct3 = 3'b110; funct7_5 = 1'b1;
    mem_ready = 1'b1;
    tick();
    step("it.dec", ST_DECODE, W_DEC, 1'b0);
    tick();
`ifdef MC_ITYPE_EN
    step("it.exec", ST_EXECI,
         cw(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b10, 4'b0110),
         1'b0);
    tick();
    step("it.wb", ST_ALUWB, W_AWB, 1'b0);
    tick();
    step("it.done", ST_FETCH, w_fetch(1'b1), 1'b0);
`else
    step("it.ill", ST_FETCH, w_fetch(1'b1), 1'b1);
    tick();
    step("it.sticky", ST_DECODE, W_DEC, 1'b1);
`endif

    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_ready = 1'b0;
    settle();
    step("final", ST_FETCH, w_fetch(1'b0), 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 SHALL have one parameter: IR_WIDTH, 32, width of the instruction word whose fields feed the decode inputs.
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port opcode  in  7  instr[6:0], stable from the cycle after ir_write.
REQ-005 SHALL have port funct3  in  3  instr[14:12].
REQ-006 SHALL have port funct7_5  in  1  instr[30].
REQ-007 SHALL have port zero  in  1  ALU zero flag.
REQ-008 SHALL have port mem_ready  in  1  memory access completes this cycle.
REQ-009 SHALL have outputs pc_write, ir_write, adr_src, mem_read, mem_write, reg_write, illegal, each 1 bit.
REQ-010 SHALL have outputs alu_src_a, alu_src_b, result_src, alu_op, each 2 bits.
REQ-011 SHALL have output alu_func  out  4  {funct7_5, funct3}; this is the func word the ALU control stage consumes.
REQ-012 SHALL have output state_o  out  4  current state, for debug.

Function
REQ-013 SHALL be a Moore FSM with these states:
  - FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, ALUWB, BEQ
  - EXECI, only when REQ-025 applies
REQ-014 SHALL use these select encodings:
  - alu_src_a: 00 PC, 01 oldPC, 10 rs1
  - alu_src_b: 00 rs2, 01 imm, 10 constant 4
  - result_src: 00 ALUOut, 01 read data, 10 ALU result
  - alu_op: 00 add, 01 sub/compare, 10 use funct
REQ-015 FETCH SHALL behave as follows:
  - Outputs: mem_read=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - While mem_ready=0: hold state; ir_write=0 and pc_write=0.
  - When mem_ready=1: ir_write=1 and pc_write=1 in that same cycle; next state is DECODE.
REQ-016 DECODE SHALL drive alu_src_a=01, alu_src_b=01, alu_op=00 and branch on opcode:
  - 0000011 (lw) or 0100011 (sw): MEMADR
  - 0110011 (R-type): EXECR
  - 1100011 (beq): BEQ
  - any other opcode: FETCH, with illegal set.
REQ-017 MEMADR SHALL drive alu_src_a=10, alu_src_b=01, alu_op=00; next state is MEMREAD for lw and MEMWRITE for sw.
REQ-018 MEMREAD SHALL drive mem_read=1, adr_src=1, result_src=00; it holds until mem_ready=1, then goes to MEMWB.
REQ-019 MEMWB SHALL drive result_src=01 and reg_write=1; next state is FETCH.
REQ-020 MEMWRITE SHALL drive mem_write=1 and adr_src=1; it holds until mem_ready=1, then goes to FETCH.
REQ-021 The ALU states SHALL behave as follows:
  - EXECR: alu_src_a=10, alu_src_b=00, alu_op=10, alu_func={funct7_5,funct3}; next state ALUWB.
  - ALUWB: result_src=00, reg_write=1; next state FETCH.
REQ-022 BEQ SHALL drive alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, pc_write=zero; next state is FETCH.
REQ-023 All outputs not listed for a state SHALL be 0, and alu_func SHALL be 0000 outside EXECR/EXECI; illegal is sticky until rst.
REQ-024 With mem_ready tied to 1, instruction latency SHALL be: R-type 4 cycles, lw 5, sw 4, beq 3.

Configuration
REQ-025 Macro MC_ITYPE_EN SHALL add I-type ALU support:
  - Defined: opcode 0010011 in DECODE goes to EXECI.
  - EXECI drives alu_src_a=10, alu_src_b=01, alu_op=10, alu_func={1'b0,funct3}; next state ALUWB.
  - Undefined: opcode 0010011 is illegal, handled as in REQ-016.

Reset
REQ-026 On rst=1 at a clock edge, the next state SHALL be FETCH and illegal SHALL be 0, from any state.
REQ-027 While rst=1, every strobe and select SHALL be 0, including while the FSM is waiting in MEMREAD or MEMWRITE; no register, memory or PC write occurs.
REQ-028 rst SHALL take priority over mem_ready and over all transitions.

Structure
REQ-029 Package mc_pkg SHALL hold the state enum, opcode constants, ALUOp codes and select encodings.
REQ-030 Sub-module mc_ctrl_decoder SHALL map state (plus funct fields and zero) combinationally to the outputs; the FSM register and next-state logic stay in mc_control_fsm.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
  - R-type: opcode 0110011, funct7_5=1, funct3=000, mem_ready=1 -> alu_op=10 and alu_func=1000 in EXECR, reg_write=1 in cycle 4, FETCH in cycle 5.
  - lw with mem_ready low 3 cycles in MEMREAD -> FSM holds, mem_read=1 throughout, then MEMWB with reg_write=1 for exactly one cycle.
  - beq: zero=1 -> pc_write=1 in BEQ; zero=0 -> pc_write=0; both return to FETCH.
  - Illegal opcode 1111111 -> illegal=1 from the cycle after DECODE, FSM back in FETCH; illegal clears only on rst.
  - rst asserted in MEMWRITE with mem_ready=0 -> next cycle FETCH, mem_write=0, illegal=0.
  - With MC_ITYPE_EN: opcode 0010011, funct3=110 -> EXECI, alu_func=0110, then ALUWB.
